// File: rtl/pong_game_ctrl.sv
// Pong match sequencer: owns the movement tick and runs IDLE/SERVE/PLAY/OVER scoring.
// Misses act on the sampling edge, start presses two edges after synchronization; no backpressure.
module pong_game_ctrl #(
    parameter int TICK_DIV    = 262144,
    parameter int SERVE_TICKS = 60,
    parameter int WIN_SCORE   = 7
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start_n,
    input  logic       miss_l,
    input  logic       miss_r,
    output logic       move_tick,
    output logic       paddle_en,
    output logic       recenter,
    output logic       ball_launch,
    output logic       serve_dir,
    output logic [3:0] score_l,
    output logic [3:0] score_r,
    output logic       winner,
    output logic [1:0] state
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SERVE = 2'd1;
    localparam logic [1:0] ST_PLAY  = 2'd2;
    localparam logic [1:0] ST_OVER  = 2'd3;

    localparam int              SC_W       = (SERVE_TICKS > 1) ? $clog2(SERVE_TICKS) : 1;
    localparam logic [17:0]     DIV_LAST   = 18'(TICK_DIV - 1);
    localparam logic [SC_W-1:0] SERVE_LAST = SC_W'(SERVE_TICKS - 1);
    localparam logic [3:0]      WIN        = 4'(WIN_SCORE);

    logic [17:0]     div_cnt;
    logic            tick;
    logic            sync_q1;
    logic            sync_q2;
    logic            sync_q3;
    logic [1:0]      warm_cnt;
    logic            press;
    logic [SC_W-1:0] serve_cnt;

    logic [1:0]      state_nxt;
    logic [SC_W-1:0] serve_cnt_nxt;
    logic [3:0]      score_l_nxt;
    logic [3:0]      score_r_nxt;
    logic            serve_dir_nxt;
    logic            winner_nxt;
    logic            recenter_nxt;
    logic            launch_nxt;

    assign tick = (div_cnt == DIV_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt <= '0;
        end else if (tick) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + 18'd1;
        end
    end

    // The edge detector only trusts the sync chain once it holds real samples,
    // so a button already held low when reset lifts is not mistaken for a press.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q1  <= 1'b1;
            sync_q2  <= 1'b1;
            sync_q3  <= 1'b1;
            warm_cnt <= 2'd0;
        end else begin
            sync_q1 <= start_n;
            sync_q2 <= sync_q1;
            sync_q3 <= sync_q2;
            if (warm_cnt != 2'd3) begin
                warm_cnt <= warm_cnt + 2'd1;
            end
        end
    end

    assign press = sync_q3 & ~sync_q2 & (warm_cnt == 2'd3);

    always_comb begin
        state_nxt     = state;
        serve_cnt_nxt = serve_cnt;
        score_l_nxt   = score_l;
        score_r_nxt   = score_r;
        serve_dir_nxt = serve_dir;
        winner_nxt    = winner;
        recenter_nxt  = 1'b0;
        launch_nxt    = 1'b0;

        case (state)
            ST_IDLE, ST_OVER: begin
                if (press) begin
                    state_nxt     = ST_SERVE;
                    serve_cnt_nxt = '0;
                    score_l_nxt   = 4'd0;
                    score_r_nxt   = 4'd0;
                    serve_dir_nxt = 1'b1;
                    winner_nxt    = 1'b0;
                    recenter_nxt  = 1'b1;
                end
            end
            ST_SERVE: begin
                if (tick) begin
                    if (serve_cnt == SERVE_LAST) begin
                        state_nxt  = ST_PLAY;
                        launch_nxt = 1'b1;
                    end else begin
                        serve_cnt_nxt = serve_cnt + SC_W'(1);
                    end
                end
            end
            ST_PLAY: begin
                if (miss_l && miss_r) begin
                    state_nxt     = ST_SERVE;
                    serve_cnt_nxt = '0;
                    recenter_nxt  = 1'b1;
                end else if (miss_l) begin
                    score_r_nxt   = score_r + 4'd1;
                    serve_dir_nxt = 1'b0;
                    if (score_r_nxt == WIN) begin
                        state_nxt  = ST_OVER;
                        winner_nxt = 1'b1;
                    end else begin
                        state_nxt     = ST_SERVE;
                        serve_cnt_nxt = '0;
                        recenter_nxt  = 1'b1;
                    end
                end else if (miss_r) begin
                    score_l_nxt   = score_l + 4'd1;
                    serve_dir_nxt = 1'b1;
                    if (score_l_nxt == WIN) begin
                        state_nxt  = ST_OVER;
                        winner_nxt = 1'b0;
                    end else begin
                        state_nxt     = ST_SERVE;
                        serve_cnt_nxt = '0;
                        recenter_nxt  = 1'b1;
                    end
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            serve_cnt   <= '0;
            score_l     <= 4'd0;
            score_r     <= 4'd0;
            serve_dir   <= 1'b1;
            winner      <= 1'b0;
            recenter    <= 1'b0;
            ball_launch <= 1'b0;
        end else begin
            state       <= state_nxt;
            serve_cnt   <= serve_cnt_nxt;
            score_l     <= score_l_nxt;
            score_r     <= score_r_nxt;
            serve_dir   <= serve_dir_nxt;
            winner      <= winner_nxt;
            recenter    <= recenter_nxt;
            ball_launch <= launch_nxt;
        end
    end

    assign paddle_en = (state == ST_PLAY);
    assign move_tick = tick & (state == ST_PLAY);

endmodule
